// File: rtl/sevenseg_to_binary_if.sv
// Handshake bundle for the seven-segment to binary converter: a segment
// triple on the input side and the converted value/error on the output side.
interface sevenseg_to_binary_if;
   logic [6:0] hundreds_sevenseg;
   logic [6:0] tens_sevenseg;
   logic [6:0] ones_sevenseg;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out;
   logic [1:0] err;
   logic       out_valid;
   logic       out_ready;

   modport slave (
      input  hundreds_sevenseg, tens_sevenseg, ones_sevenseg, in_valid, out_ready,
      output in_ready, out, err, out_valid
   );

   modport master (
      output hundreds_sevenseg, tens_sevenseg, ones_sevenseg, in_valid, out_ready,
      input  in_ready, out, err, out_valid
   );
endinterface

// File: rtl/sevenseg_to_binary.sv
// Converts a three-digit seven-segment image back to an 8-bit value by decoding
// each digit and accumulating acc = acc*10 + digit serially with shift-add.
module sevenseg_to_binary #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   sevenseg_to_binary_if.slave         bus
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_BAD  = 2'b01;
   localparam logic [1:0] ERR_OVFL = 2'b10;

   state_t     state_q, state_d;
   logic [3:0] hund_q, hund_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       bad_q, bad_d;
   logic [9:0] acc_q, acc_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] out_q, out_d;
   logic [1:0] err_q, err_d;

   // Returns {ok, digit}; unknown codes (including blank) report ok=0, digit=0.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'h3F:   return 5'h10;
         7'h06:   return 5'h11;
         7'h5B:   return 5'h12;
         7'h4F:   return 5'h13;
         7'h66:   return 5'h14;
         7'h6D:   return 5'h15;
         7'h7D:   return 5'h16;
         7'h07:   return 5'h17;
         7'h7F:   return 5'h18;
         7'h6F:   return 5'h19;
         default: return 5'h00;
      endcase
   endfunction

   logic [6:0] seg_h, seg_t, seg_o;
   logic [4:0] dec_h, dec_t, dec_o;
   logic       h_blank, t_blank;
   logic       h_ok, t_ok, o_ok;
   logic [3:0] dig_sel;

   assign seg_h = ACTIVE_LOW ? ~bus.hundreds_sevenseg : bus.hundreds_sevenseg;
   assign seg_t = ACTIVE_LOW ? ~bus.tens_sevenseg     : bus.tens_sevenseg;
   assign seg_o = ACTIVE_LOW ? ~bus.ones_sevenseg     : bus.ones_sevenseg;

   assign dec_h = seg_decode(seg_h);
   assign dec_t = seg_decode(seg_t);
   assign dec_o = seg_decode(seg_o);

   // Leading-zero blanking: tens may be blank only behind a blank hundreds;
   // a blank ones digit is never legal.
   assign h_blank = (seg_h == 7'h00);
   assign t_blank = (seg_t == 7'h00);
   assign h_ok    = dec_h[4] | h_blank;
   assign t_ok    = dec_t[4] | (t_blank & h_blank);
   assign o_ok    = dec_o[4];

   always_comb begin
      case (idx_q)
         2'd0:    dig_sel = hund_q;
         2'd1:    dig_sel = tens_q;
         default: dig_sel = ones_q;
      endcase
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      bad_d   = bad_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      out_d   = out_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               hund_d  = dec_h[3:0];
               tens_d  = dec_t[3:0];
               ones_d  = dec_o[3:0];
               bad_d   = ~(h_ok & t_ok & o_ok);
               acc_d   = 10'd0;
               idx_d   = 2'd0;
               state_d = ACC;
            end
         end
         ACC: begin
            if (idx_q == 2'd3) begin
               if (bad_q) begin
                  out_d = 8'h00;
                  err_d = ERR_BAD;
               end else if (acc_q > 10'd255) begin
                  out_d = 8'hFF;
                  err_d = ERR_OVFL;
               end else begin
                  out_d = acc_q[7:0];
                  err_d = ERR_OK;
               end
               state_d = DONE;
            end else begin
               acc_d = (acc_q << 3) + (acc_q << 1) + {6'd0, dig_sel};
               idx_d = idx_q + 2'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the digit registers are ordinary flops, so they are reset along with the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hund_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         bad_q   <= 1'b0;
         acc_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         bad_q   <= bad_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out       = out_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_sevenseg_to_binary.sv
// Directed bench for sevenseg_to_binary: latency, overflow, bad patterns,
// blanking, backpressure, active-low inputs and reset during conversion.
module tb_sevenseg_to_binary;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sevenseg_to_binary_if bus0 ();
   sevenseg_to_binary_if bus1 ();

   sevenseg_to_binary #(.ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   sevenseg_to_binary #(.ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one triple on bus0, waits (bounded) for out_valid, returns the
   // result and the edge count after the accept edge, then lets the result drain.
   task automatic run_conv(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o,
                           output logic [7:0] r_out, output logic [1:0] r_err, output int lat);
      bus0.hundreds_sevenseg = h;
      bus0.tens_sevenseg     = t;
      bus0.ones_sevenseg     = o;
      bus0.in_valid          = 1'b1;
      step();
      bus0.in_valid = 1'b0;
      lat   = 0;
      r_out = 8'h00;
      r_err = 2'b00;
      while (lat < 20) begin
         step();
         lat++;
         if (bus0.out_valid) break;
      end
      r_out = bus0.out;
      r_err = bus0.err;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
      bus0.hundreds_sevenseg = 7'h00; bus0.tens_sevenseg = 7'h00; bus0.ones_sevenseg = 7'h00;
      bus1.hundreds_sevenseg = 7'h7F; bus1.tens_sevenseg = 7'h7F; bus1.ones_sevenseg = 7'h7F;
      #12;
      checks++;
      if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: in_ready=%b out_valid=%b, expected 1 0", bus0.in_ready, bus0.out_valid);
      end
      checks++;
      if (bus0.out !== 8'h00 || bus0.err !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs: out=%h err=%b, expected 00 00", bus0.out, bus0.err);
      end
      checks++;
      if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut1: in_ready=%b out_valid=%b, expected 1 0", bus1.in_ready, bus1.out_valid);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_latency();
      bus0.hundreds_sevenseg = 7'h5B;
      bus0.tens_sevenseg     = 7'h6D;
      bus0.ones_sevenseg     = 7'h6D;
      bus0.in_valid          = 1'b1;
      step();
      bus0.in_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_busy_k+%0d: in_ready=%b out_valid=%b, expected 0 0", i, bus0.in_ready, bus0.out_valid);
         end
      end
      step();
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0 || bus0.out !== 8'hFF || bus0.err !== 2'b00) begin
         errors++;
         $display("FAIL latency_k+4: out_valid=%b in_ready=%b out=%h err=%b, expected 1 0 ff 00",
                  bus0.out_valid, bus0.in_ready, bus0.out, bus0.err);
      end
      step();
      checks++;
      if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL latency_release: out_valid=%b in_ready=%b, expected 0 1", bus0.out_valid, bus0.in_ready);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] o; logic [1:0] e; int lat;
      run_conv(7'h5B, 7'h6D, 7'h7D, o, e, lat);
      checks++;
      if (lat !== 4 || o !== 8'hFF || e !== 2'b10) begin
         errors++;
         $display("FAIL overflow_256: out=%h err=%b lat=%0d, expected ff 10 4", o, e, lat);
      end
      run_conv(7'h6F, 7'h6F, 7'h6F, o, e, lat);
      checks++;
      if (lat !== 4 || o !== 8'hFF || e !== 2'b10) begin
         errors++;
         $display("FAIL overflow_999: out=%h err=%b lat=%0d, expected ff 10 4", o, e, lat);
      end
   endtask

   task automatic test_bad_pattern();
      logic [7:0] o; logic [1:0] e; int lat;
      run_conv(7'h06, 7'h7E, 7'h3F, o, e, lat);
      checks++;
      if (lat !== 4 || o !== 8'h00 || e !== 2'b01) begin
         errors++;
         $display("FAIL bad_tens: out=%h err=%b lat=%0d, expected 00 01 4", o, e, lat);
      end
   endtask

   task automatic test_blanking();
      logic [6:0] vh [4] = '{7'h00, 7'h00, 7'h06, 7'h00};
      logic [6:0] vt [4] = '{7'h00, 7'h3F, 7'h00, 7'h00};
      logic [6:0] vo [4] = '{7'h07, 7'h3F, 7'h3F, 7'h00};
      logic [7:0] xo [4] = '{8'h07, 8'h00, 8'h00, 8'h00};
      logic [1:0] xe [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
      logic [7:0] o; logic [1:0] e; int lat;
      for (int i = 0; i < 4; i++) begin
         run_conv(vh[i], vt[i], vo[i], o, e, lat);
         checks++;
         if (lat !== 4 || o !== xo[i] || e !== xe[i]) begin
            errors++;
            $display("FAIL blanking_%0d: out=%h err=%b lat=%0d, expected %h %b 4", i, o, e, lat, xo[i], xe[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int hold_bad = 0;
      bus0.out_ready         = 1'b0;
      bus0.hundreds_sevenseg = 7'h06;
      bus0.tens_sevenseg     = 7'h5B;
      bus0.ones_sevenseg     = 7'h4F;
      bus0.in_valid          = 1'b1;
      step();
      bus0.in_valid = 1'b0;
      repeat (4) step();
      for (int i = 0; i < 6; i++) begin
         bus0.hundreds_sevenseg = 7'h3F;
         bus0.in_valid          = i[0];
         if (bus0.out_valid !== 1'b1 || bus0.out !== 8'h7B || bus0.err !== 2'b00 || bus0.in_ready !== 1'b0)
            hold_bad++;
         step();
      end
      bus0.in_valid = 1'b0;
      checks++;
      if (hold_bad != 0 || bus0.out_valid !== 1'b1 || bus0.out !== 8'h7B) begin
         errors++;
         $display("FAIL backpressure_hold: bad_cycles=%0d out_valid=%b out=%h, expected 0 1 7b",
                  hold_bad, bus0.out_valid, bus0.out);
      end
      bus0.out_ready = 1'b1;
      step();
      checks++;
      if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.out !== 8'h7B || bus0.err !== 2'b00) begin
         errors++;
         $display("FAIL backpressure_release: out_valid=%b in_ready=%b out=%h err=%b, expected 0 1 7b 00",
                  bus0.out_valid, bus0.in_ready, bus0.out, bus0.err);
      end
   endtask

   task automatic test_active_low();
      int lat = 0;
      bus1.hundreds_sevenseg = 7'h79;
      bus1.tens_sevenseg     = 7'h24;
      bus1.ones_sevenseg     = 7'h30;
      bus1.in_valid          = 1'b1;
      step();
      bus1.in_valid = 1'b0;
      while (lat < 20) begin
         step();
         lat++;
         if (bus1.out_valid) break;
      end
      checks++;
      if (lat !== 4 || bus1.out !== 8'h7B || bus1.err !== 2'b00) begin
         errors++;
         $display("FAIL active_low_123: out=%h err=%b lat=%0d, expected 7b 00 4", bus1.out, bus1.err, lat);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      logic [7:0] o; logic [1:0] e; int lat;
      bus0.hundreds_sevenseg = 7'h06;
      bus0.tens_sevenseg     = 7'h5B;
      bus0.ones_sevenseg     = 7'h4F;
      bus0.in_valid          = 1'b1;
      step();
      bus0.in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.out !== 8'h00 || bus0.err !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid_async: out_valid=%b in_ready=%b out=%h err=%b, expected 0 1 00 00",
                  bus0.out_valid, bus0.in_ready, bus0.out, bus0.err);
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus0.out_valid !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_mid_no_pulse: out_valid_cycles=%0d, expected 0", pulses);
      end
      run_conv(7'h00, 7'h06, 7'h3F, o, e, lat);
      checks++;
      if (lat !== 4 || o !== 8'h0A || e !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid_recover: out=%h err=%b lat=%0d, expected 0a 00 4", o, e, lat);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_overflow();
      test_bad_pattern();
      test_blanking();
      test_backpressure();
      test_active_low();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
